shift_sequencer: RTL and testbench

Command-driven controller placed directly upstream of the 4-bit universal shift register. Accepts one load/shift/hold command per valid/ready handshake and drives the register's select, parallel-data and serial-in pins cycle-by-cycle. Pulses `done` once the register's output port shows the command's final value.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_sequencer.sv | 127 ++++++++++++
 tb/tb_shift_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer and its downstream
// universal shift register.
//   - OP_* : command opcodes, numerically identical to the register's
//            select codes, so a shift/hold opcode drives sel directly.
//   - state_t : sequencer FSM states.
//   - DEF_WIDTH : default data width.
package shift_pkg;
  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DRAIN = 2'b11
  } state_t;
endpackage

// File: rtl/shift_sequencer.sv
// shift_sequencer: accepts one load/shift/hold command per valid/ready
// handshake and drives a universal shift register cycle by cycle.
// Ports:
//   clock, reset         - clock; synchronous active-high reset
//   cmd_valid/cmd_ready  - command handshake (ready only in IDLE, not in reset)
//   cmd_op               - 00 load, 01 left, 10 right, 11 hold
//   cmd_data             - load value, or serial bits (LSB first) for shifts
//   cmd_count            - shift/hold step count, saturated to WIDTH
//   sel                  - register select
//   data_input           - register parallel-load value
//   left_in, right_in    - serial bit for the current step
//   done                 - one-cycle pulse once the register output is final
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] data_input,
  output logic             left_in,
  output logic             right_in,
  output logic             done
);

  state_t           state, state_n;
  logic [1:0]       sel_n;
  logic [WIDTH-1:0] din_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ser, ser_n;
  logic             done_n;
  logic [CNT_W-1:0] steps;
  logic             accept;

  assign cmd_ready = (state == S_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign steps     = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;

  // One serial register feeds both pins; the register only looks at the
  // one that matches the current select.
  assign left_in  = ser;
  assign right_in = ser;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      sel        <= OP_HOLD;
      data_input <= '0;
      ser        <= 1'b0;
      done       <= 1'b0;
      shadow     <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      data_input <= din_n;
      ser        <= ser_n;
      done       <= done_n;
      shadow     <= shadow_n;
      cnt        <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    din_n    = data_input;
    ser_n    = 1'b0;
    done_n   = 1'b0;
    shadow_n = shadow;
    cnt_n    = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_LOAD) begin
            state_n = S_LOAD;
            sel_n   = OP_LOAD;
            din_n   = cmd_data;
          end else if (steps != '0) begin
            // Step 0's bit goes out now; the shadow holds the rest and
            // cnt counts the steps still to come after this one.
            state_n  = S_SHIFT;
            sel_n    = cmd_op;
            ser_n    = cmd_data[0];
            shadow_n = cmd_data >> 1;
            cnt_n    = steps - CNT_W'(1);
          end else begin
            state_n = S_DRAIN;
            sel_n   = OP_HOLD;
          end
        end
      end
      S_LOAD: begin
        state_n = S_DRAIN;
        sel_n   = OP_HOLD;
      end
      S_SHIFT: begin
        if (cnt == '0) begin
          state_n = S_DRAIN;
          sel_n   = OP_HOLD;
        end else begin
          ser_n    = shadow[0];
          shadow_n = shadow >> 1;
          cnt_n    = cnt - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // Covers the register's output latency before signalling done.
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
        sel_n   = OP_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: shift_sequencer driving a behavioural 4-bit universal
// shift register whose output port lags its internal state by one cycle.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_count;
  logic [1:0] sel;
  logic [3:0] data_input;
  logic       left_in, right_in, done;

  logic [3:0] q, q_out;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .sel(sel), .data_input(data_input),
    .left_in(left_in), .right_in(right_in), .done(done)
  );

  // Downstream universal register.
  always_ff @(posedge clock) begin
    if (reset) begin
      q     <= '0;
      q_out <= '0;
    end else begin
      case (sel)
        2'b00: q <= data_input;
        2'b01: q <= {q[2:0], left_in};
        2'b10: q <= {right_in, q[3:1]};
        default: q <= q;
      endcase
      q_out <= q;
    end
  end

  // Issues a command at the next edge and follows it to the cycle after
  // done. Called #1 after an edge with the sequencer idle.
  task automatic run_cmd(input string name, input logic [1:0] op,
                         input logic [3:0] data, input logic [2:0] count,
                         input int n, input logic [3:0] exp_q);
    logic [1:0] exp_sel;
    exp_sel = op;
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL %s ready_before: got %b want 1", name, cmd_ready);
    end
    cmd_op = op; cmd_data = data; cmd_count = count; cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (sel !== exp_sel) begin
        fails++; $display("FAIL %s sel_c%0d: got %b want %b", name, c, sel, exp_sel);
      end
      checks++;
      if (cmd_ready !== 1'b0) begin
        fails++; $display("FAIL %s ready_busy_c%0d: got %b want 0", name, c, cmd_ready);
      end
      if (op == OP_LOAD) begin
        checks++;
        if (data_input !== data) begin
          fails++; $display("FAIL %s data_input: got %b want %b", name, data_input, data);
        end
      end else begin
        checks++;
        if (left_in !== data[c-1] || right_in !== data[c-1]) begin
          fails++; $display("FAIL %s serial_c%0d: got %b/%b want %b", name, c,
                            left_in, right_in, data[c-1]);
        end
      end
      @(posedge clock); #1;
    end
    checks++;
    if (sel !== 2'b11 || done !== 1'b0 || left_in !== 1'b0) begin
      fails++; $display("FAIL %s drain: got sel=%b done=%b li=%b want 11/0/0",
                        name, sel, done, left_in);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b1 || q_out !== exp_q || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL %s done_edge: got done=%b q=%b rdy=%b want 1/%b/1",
                        name, done, q_out, cmd_ready, exp_q);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL %s done_pulse: got %b want 0", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; cmd_count = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (sel !== 2'b11 || data_input !== 4'b0000 || left_in !== 1'b0 ||
        right_in !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++; $display("FAIL reset_vals: got sel=%b din=%b li=%b ri=%b done=%b rdy=%b",
                        sel, data_input, left_in, right_in, done, cmd_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_load();
    run_cmd("load", OP_LOAD, 4'b1011, 3'd0, 1, 4'b1011);
  endtask

  task automatic test_shift_left();
    run_cmd("shl2", OP_SHL, 4'b0001, 3'd2, 2, 4'b1110);
  endtask

  task automatic test_shift_right();
    run_cmd("shr3", OP_SHR, 4'b0110, 3'd3, 3, 4'b1101);
  endtask

  task automatic test_saturate();
    run_cmd("shl7_sat", OP_SHL, 4'b0110, 3'd7, 4, 4'b0110);
  endtask

  task automatic test_zero_count();
    run_cmd("zero", OP_SHL, 4'b1111, 3'd0, 0, 4'b0110);
  endtask

  task automatic test_hold();
    run_cmd("hold2", OP_HOLD, 4'b0000, 3'd2, 2, 4'b0110);
  endtask

  task automatic test_back_to_back();
    cmd_op = OP_LOAD; cmd_data = 4'b0101; cmd_count = 3'd0; cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_op = OP_SHR; cmd_data = 4'b0001; cmd_count = 3'd1;
    checks++;
    if (cmd_ready !== 1'b0 || sel !== 2'b00) begin
      fails++; $display("FAIL b2b_c1: got rdy=%b sel=%b want 0/00", cmd_ready, sel);
    end
    @(posedge clock); #1;
    checks++;
    if (cmd_ready !== 1'b0 || sel !== 2'b11) begin
      fails++; $display("FAIL b2b_c2: got rdy=%b sel=%b want 0/11", cmd_ready, sel);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || q_out !== 4'b0101) begin
      fails++; $display("FAIL b2b_done1: got done=%b rdy=%b q=%b want 1/1/0101",
                        done, cmd_ready, q_out);
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    checks++;
    if (sel !== 2'b10 || right_in !== 1'b1 || cmd_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_second_accept: got sel=%b ri=%b rdy=%b want 10/1/0",
                        sel, right_in, cmd_ready);
    end
    @(posedge clock); #1;
    checks++;
    if (sel !== 2'b11 || done !== 1'b0) begin
      fails++; $display("FAIL b2b_drain2: got sel=%b done=%b want 11/0", sel, done);
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b1 || q_out !== 4'b1010) begin
      fails++; $display("FAIL b2b_done2: got done=%b q=%b want 1/1010", done, q_out);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    cmd_op = OP_SHL; cmd_data = 4'b1111; cmd_count = 3'd4; cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      fails++; $display("FAIL rst_mid_ready: got %b want 0", cmd_ready);
    end
    @(posedge clock); #1;
    checks++;
    if (sel !== 2'b11 || left_in !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL rst_mid_abort: got sel=%b li=%b done=%b want 11/0/0",
                        sel, left_in, done);
    end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
        fails++; $display("FAIL rst_mid_quiet_c%0d: got done=%b rdy=%b want 0/1",
                          c, done, cmd_ready);
      end
    end
    run_cmd("load_after_rst", OP_LOAD, 4'b0011, 3'd0, 1, 4'b0011);
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift_left();
    test_shift_right();
    test_saturate();
    test_zero_count();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
